// File: rtl/rob_mc_if.sv
// Dispatch, writeback, commit and flush signal bundle for the reorder buffer.
// slave is the ROB's view of the bundle; master is the core/driver view.
interface rob_mc_if #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned IDX_W    = $clog2(DEPTH),
    parameter int unsigned NUM_WB   = 4,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARCH_W   = 5
);
    logic                         alloc_valid_i;
    logic                         alloc_ready_o;
    logic [ARCH_W-1:0]            alloc_rd_i;
    logic                         alloc_we_i;
    logic [31:0]                  alloc_pc_i;
    logic [IDX_W-1:0]             alloc_idx_o;
    logic [NUM_WB-1:0]            wb_valid_i;
    logic [NUM_WB*IDX_W-1:0]      wb_idx_i;
    logic [NUM_WB*DATA_W-1:0]     wb_data_i;
    logic [NUM_WB-1:0]            wb_mispred_i;
    logic [NUM_WB*32-1:0]         wb_pc_new_i;
    logic [COMMIT_W-1:0]          commit_valid_o;
    logic                         commit_ready_i;
    logic [COMMIT_W*ARCH_W-1:0]   commit_rd_o;
    logic [COMMIT_W-1:0]          commit_we_o;
    logic [COMMIT_W*DATA_W-1:0]   commit_data_o;
    logic [COMMIT_W*32-1:0]       commit_pc_o;
    logic [COMMIT_W*IDX_W-1:0]    commit_idx_o;
    logic                         flush_o;
    logic [31:0]                  flush_pc_o;
    logic [IDX_W:0]               count_o;
    logic                         empty_o;
    logic                         full_o;

    modport slave (
        input  alloc_valid_i, alloc_rd_i, alloc_we_i, alloc_pc_i,
        input  wb_valid_i, wb_idx_i, wb_data_i, wb_mispred_i, wb_pc_new_i,
        input  commit_ready_i,
        output alloc_ready_o, alloc_idx_o,
        output commit_valid_o, commit_rd_o, commit_we_o, commit_data_o, commit_pc_o, commit_idx_o,
        output flush_o, flush_pc_o, count_o, empty_o, full_o
    );

    modport master (
        output alloc_valid_i, alloc_rd_i, alloc_we_i, alloc_pc_i,
        output wb_valid_i, wb_idx_i, wb_data_i, wb_mispred_i, wb_pc_new_i,
        output commit_ready_i,
        input  alloc_ready_o, alloc_idx_o,
        input  commit_valid_o, commit_rd_o, commit_we_o, commit_data_o, commit_pc_o, commit_idx_o,
        input  flush_o, flush_pc_o, count_o, empty_o, full_o
    );
endinterface

// File: rtl/rob_mc.sv
// Multi-port reorder buffer: one dispatch per cycle, NUM_WB writebacks, up to
// COMMIT_W in-order retirements, and a commit-time mispredict flush.
module rob_mc #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned IDX_W    = $clog2(DEPTH),
    parameter int unsigned NUM_WB   = 4,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARCH_W   = 5
) (
    input logic     clk,
    input logic     rst,
    rob_mc_if.slave bus
);
    typedef enum logic [1:0] {E_FREE, E_WAIT, E_DONE} ent_e;

    localparam logic [IDX_W:0] DEPTH_P = (IDX_W+1)'(DEPTH);

    ent_e              st_q [DEPTH];
    ent_e              st_d [DEPTH];
    logic [IDX_W:0]    head_q, head_d, tail_q, tail_d;
    logic [ARCH_W-1:0] rd_q   [DEPTH];
    logic              we_q   [DEPTH];
    logic [31:0]       pc_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              mis_q  [DEPTH];
    logic [31:0]       pcn_q  [DEPTH];

    logic [IDX_W:0]      count;
    logic                full, flush, alloc_ready, alloc_fire, run, any_mis;
    logic [31:0]         mis_pc;
    logic [IDX_W:0]      ncommit;
    logic [COMMIT_W-1:0] cvalid;
    logic [IDX_W-1:0]    cidx [COMMIT_W];
    logic [IDX_W-1:0]    wb_idx [NUM_WB];
    logic [NUM_WB-1:0]   wb_hit, wb_in_rng;

    assign count       = tail_q - head_q;
    assign full        = (count == DEPTH_P);
    assign alloc_ready = !full && !flush;
    assign alloc_fire  = bus.alloc_valid_i && alloc_ready;
    assign flush       = bus.commit_ready_i && any_mis;

    // Commit window stops at the first non-DONE entry or right after a mispredict.
    always_comb begin
        cvalid  = '0;
        ncommit = '0;
        any_mis = 1'b0;
        mis_pc  = '0;
        run     = 1'b1;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            cidx[k] = head_q[IDX_W-1:0] + IDX_W'(k);
            if (run && ((IDX_W+1)'(k) < count) && (st_q[cidx[k]] == E_DONE)) begin
                cvalid[k] = 1'b1;
                ncommit   = ncommit + 1'b1;
                if (mis_q[cidx[k]]) begin
                    any_mis = 1'b1;
                    mis_pc  = pcn_q[cidx[k]];
                    run     = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            wb_idx[p]    = bus.wb_idx_i[p*IDX_W +: IDX_W];
            wb_hit[p]    = bus.wb_valid_i[p] && (st_q[wb_idx[p]] == E_WAIT) && !flush;
            wb_in_rng[p] = {1'b0, wb_idx[p] - head_q[IDX_W-1:0]} < count;
        end
    end

    always_comb begin
        st_d   = st_q;
        head_d = head_q;
        tail_d = tail_q;
        if (bus.commit_ready_i) begin
            for (int unsigned k = 0; k < COMMIT_W; k++)
                if (cvalid[k]) st_d[cidx[k]] = E_FREE;
            head_d = head_q + ncommit;
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) st_d[i] = E_FREE;
            head_d = '0;
            tail_d = '0;
        end else begin
            for (int unsigned p = 0; p < NUM_WB; p++)
                if (wb_hit[p]) st_d[wb_idx[p]] = E_DONE;
            if (alloc_fire) begin
                st_d[tail_q[IDX_W-1:0]] = E_WAIT;
                tail_d = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) st_q[i] <= E_FREE;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            st_q   <= st_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Highest port first, so the lowest-numbered port's write lands last and wins.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail_q[IDX_W-1:0]]  <= bus.alloc_rd_i;
            we_q[tail_q[IDX_W-1:0]]  <= bus.alloc_we_i;
            pc_q[tail_q[IDX_W-1:0]]  <= bus.alloc_pc_i;
            mis_q[tail_q[IDX_W-1:0]] <= 1'b0;
        end
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (wb_hit[NUM_WB-1-i]) begin
                data_q[wb_idx[NUM_WB-1-i]] <= bus.wb_data_i[(NUM_WB-1-i)*DATA_W +: DATA_W];
                mis_q[wb_idx[NUM_WB-1-i]]  <= bus.wb_mispred_i[NUM_WB-1-i];
                pcn_q[wb_idx[NUM_WB-1-i]]  <= bus.wb_pc_new_i[(NUM_WB-1-i)*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned p = 0; p < NUM_WB; p++)
                if (bus.wb_valid_i[p])
                    assert (wb_in_rng[p])
                    else $error("rob_mc: wb port %0d targets idx %0d outside [head,tail)", p, wb_idx[p]);
        end
    end

    always_comb begin
        bus.commit_rd_o   = '0;
        bus.commit_we_o   = '0;
        bus.commit_data_o = '0;
        bus.commit_pc_o   = '0;
        bus.commit_idx_o  = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            bus.commit_rd_o[k*ARCH_W +: ARCH_W]   = rd_q[cidx[k]];
            bus.commit_we_o[k]                    = we_q[cidx[k]];
            bus.commit_data_o[k*DATA_W +: DATA_W] = data_q[cidx[k]];
            bus.commit_pc_o[k*32 +: 32]           = pc_q[cidx[k]];
            bus.commit_idx_o[k*IDX_W +: IDX_W]    = cidx[k];
        end
    end

    assign bus.alloc_ready_o  = alloc_ready;
    assign bus.alloc_idx_o    = tail_q[IDX_W-1:0];
    assign bus.commit_valid_o = cvalid;
    assign bus.flush_o        = flush;
    assign bus.flush_pc_o     = flush ? mis_pc : '0;
    assign bus.count_o        = count;
    assign bus.empty_o        = (head_q == tail_q);
    assign bus.full_o         = full;
endmodule

// File: tb/tb_rob_mc.sv
// Scoreboard bench for rob_mc: a queue-based program-order model predicts each
// cycle's status and retirements; a negedge monitor compares what the DUT presents.
module tb_rob_mc;
    localparam int DEPTH = 8, IDX_W = 3, NUM_WB = 4, COMMIT_W = 2, DATA_W = 32, ARCH_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_mc_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W),
                .DATA_W(DATA_W), .ARCH_W(ARCH_W)) bus ();

    rob_mc #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W),
             .DATA_W(DATA_W), .ARCH_W(ARCH_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          idx;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        bit          done;
        logic [31:0] data;
        bit          mis;
        logic [31:0] pcn;
    } ent_t;

    typedef struct {
        int          cnt;
        bit          ardy;
        int          aidx;
        int          ncom;
        bit          fl;
        logic [31:0] flpc;
    } stat_t;

    ent_t  rob[$];
    ent_t  rq[$];
    stat_t sq[$];
    int    tail_m = 0;
    int    checks = 0;
    int    errors = 0;

    logic [3:0]  s_wbv = '0;
    int          s_wbi [4];
    logic [31:0] s_wbd [4];
    bit          s_wbm [4];
    logic [31:0] s_wbp [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_wb(input int p, input int idx, input logic [31:0] d, input bit m, input logic [31:0] pn);
        s_wbv[p] = 1'b1;
        s_wbi[p] = idx;
        s_wbd[p] = d;
        s_wbm[p] = m;
        s_wbp[p] = pn;
    endtask

    // One cycle: predict outputs from the model, drive inputs, then advance the model past the edge.
    task automatic step(input bit av, input bit cr, input bit r);
        stat_t       st;
        ent_t        ne, t;
        int          n;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        @(posedge clk);
        #1;
        n = 0;
        while (n < COMMIT_W && n < rob.size() && rob[n].done) begin
            n++;
            if (rob[n-1].mis) break;
        end
        st.cnt  = rob.size();
        st.fl   = cr && n > 0 && rob[n-1].mis;
        st.ardy = (rob.size() < DEPTH) && !st.fl;
        st.aidx = tail_m;
        st.ncom = n;
        st.flpc = st.fl ? rob[n-1].pcn : 32'h0;
        sq.push_back(st);
        if (cr) for (int i = 0; i < n; i++) rq.push_back(rob[i]);

        rd = 5'($urandom);
        we = 1'($urandom);
        pc = $urandom;
        bus.alloc_valid_i  = av;
        bus.alloc_rd_i     = rd;
        bus.alloc_we_i     = we;
        bus.alloc_pc_i     = pc;
        bus.commit_ready_i = cr;
        for (int p = 0; p < NUM_WB; p++) begin
            bus.wb_valid_i[p]              = s_wbv[p];
            bus.wb_idx_i[p*IDX_W +: IDX_W] = 3'(s_wbi[p]);
            bus.wb_data_i[p*32 +: 32]      = s_wbd[p];
            bus.wb_mispred_i[p]            = s_wbm[p];
            bus.wb_pc_new_i[p*32 +: 32]    = s_wbp[p];
        end
        rst = r;

        if (r || st.fl) begin
            rob.delete();
            tail_m = 0;
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (!s_wbv[p]) continue;
                for (int j = 0; j < rob.size(); j++) begin
                    if (rob[j].idx == s_wbi[p] && !rob[j].done) begin
                        t = rob[j];
                        t.done = 1'b1;
                        t.data = s_wbd[p];
                        t.mis  = s_wbm[p];
                        t.pcn  = s_wbp[p];
                        rob[j] = t;
                    end
                end
            end
            if (cr) repeat (n) void'(rob.pop_front());
            if (av && st.ardy) begin
                ne.idx = tail_m; ne.rd = rd; ne.we = we; ne.pc = pc;
                ne.done = 1'b0; ne.data = '0; ne.mis = 1'b0; ne.pcn = '0;
                rob.push_back(ne);
                tail_m = (tail_m + 1) % DEPTH;
            end
        end
        s_wbv = '0;
    endtask

    stat_t me;
    ent_t  mx;
    always @(negedge clk) begin
        if (sq.size() > 0) begin
            me = sq.pop_front();
            chk("count", 64'(bus.count_o), 64'(me.cnt));
            chk("empty", 64'(bus.empty_o), 64'(me.cnt == 0));
            chk("full", 64'(bus.full_o), 64'(me.cnt == DEPTH));
            chk("alloc_ready", 64'(bus.alloc_ready_o), 64'(me.ardy));
            chk("alloc_idx", 64'(bus.alloc_idx_o), 64'(me.aidx));
            chk("commit_valid", 64'(bus.commit_valid_o), 64'((1 << me.ncom) - 1));
            chk("flush", 64'(bus.flush_o), 64'(me.fl));
            chk("flush_pc", 64'(bus.flush_pc_o), 64'(me.flpc));
            if (bus.commit_ready_i) begin
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (!bus.commit_valid_o[k]) continue;
                    if (rq.size() == 0) begin
                        chk("retire_unexpected", 64'(bus.commit_idx_o[k*IDX_W +: IDX_W]), 64'hFFFF);
                    end else begin
                        mx = rq.pop_front();
                        chk("commit_idx", 64'(bus.commit_idx_o[k*IDX_W +: IDX_W]), 64'(mx.idx));
                        chk("commit_rd", 64'(bus.commit_rd_o[k*ARCH_W +: ARCH_W]), 64'(mx.rd));
                        chk("commit_we", 64'(bus.commit_we_o[k]), 64'(mx.we));
                        chk("commit_data", 64'(bus.commit_data_o[k*DATA_W +: DATA_W]), 64'(mx.data));
                        chk("commit_pc", 64'(bus.commit_pc_o[k*32 +: 32]), 64'(mx.pc));
                    end
                end
            end
        end
    end

    task automatic wb_range(input int first, input int num);
        for (int p = 0; p < num; p++) set_wb(p, (first + p) % DEPTH, $urandom, 1'b0, $urandom);
    endtask

    initial begin
        int j;
        bus.alloc_valid_i  = 1'b0;
        bus.alloc_rd_i     = '0;
        bus.alloc_we_i     = 1'b0;
        bus.alloc_pc_i     = '0;
        bus.wb_valid_i     = '0;
        bus.wb_idx_i       = '0;
        bus.wb_data_i      = '0;
        bus.wb_mispred_i   = '0;
        bus.wb_pc_new_i    = '0;
        bus.commit_ready_i = 1'b1;
        repeat (2) @(posedge clk);

        step(0, 1, 0);                               // reset state
        repeat (8) step(1, 1, 0);                    // fill to full
        step(1, 1, 0);                               // full refuses
        wb_range(0, 4); step(0, 1, 0);
        wb_range(4, 4); step(0, 1, 0);
        repeat (5) step(0, 1, 0);                    // drain 2,2,2,2

        repeat (4) step(1, 1, 0);                    // out-of-order writeback
        set_wb(0, 3, $urandom, 0, 0); set_wb(1, 2, $urandom, 0, 0); set_wb(2, 1, $urandom, 0, 0);
        step(0, 1, 0); step(0, 1, 0);
        set_wb(0, 0, $urandom, 0, 0); step(0, 1, 0);
        repeat (3) step(0, 1, 0);

        step(0, 1, 1);                               // mispredict at idx 1
        repeat (5) step(1, 1, 0);
        wb_range(0, 4); set_wb(1, 1, 32'h11, 1'b1, 32'h1234); step(0, 1, 0);
        set_wb(0, 4, $urandom, 0, 0); step(0, 1, 0);
        repeat (3) step(0, 1, 0);

        repeat (2) step(1, 1, 0);                    // allocation during flush
        set_wb(0, 0, $urandom, 1'b1, 32'hCAFE); step(0, 1, 0);
        set_wb(0, 1, $urandom, 0, 0); step(1, 1, 0);
        step(0, 1, 0);

        repeat (6) step(1, 1, 0);                    // same-index port conflict
        set_wb(0, 5, 32'hAA, 0, 0); set_wb(2, 5, 32'hBB, 0, 0);
        set_wb(1, 0, $urandom, 0, 0); set_wb(3, 1, $urandom, 0, 0); step(0, 1, 0);
        set_wb(0, 2, $urandom, 0, 0); set_wb(1, 3, $urandom, 0, 0); set_wb(2, 4, $urandom, 0, 0);
        step(0, 1, 0);
        repeat (4) step(0, 1, 0);

        step(0, 1, 1);                               // backpressure
        repeat (2) step(1, 1, 0);
        wb_range(0, 2); step(0, 0, 0);
        repeat (3) step(0, 0, 0);
        repeat (2) step(0, 1, 0);

        step(0, 1, 1);                               // wrap-around
        repeat (6) step(1, 1, 0);
        wb_range(0, 4); step(0, 1, 0);
        wb_range(4, 2); step(0, 1, 0);
        repeat (4) step(0, 1, 0);
        repeat (6) step(1, 1, 0);
        wb_range(6, 4); step(0, 1, 0);
        wb_range(2, 2); step(0, 1, 0);
        repeat (4) step(0, 1, 0);

        repeat (5) step(1, 1, 0);                    // reset with pending entries
        wb_range(tail_m + DEPTH - 5, 2); step(0, 1, 1);
        step(0, 1, 0);

        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (rob.size() > 0 && $urandom_range(0, 2) == 0) begin
                    j = int'($urandom_range(0, rob.size() - 1));
                    set_wb(p, rob[j].idx, $urandom, ($urandom_range(0, 11) == 0), $urandom);
                end
            end
            step($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        step(0, 1, 0);

        @(negedge clk);
        #1;
        chk("retire_leftover", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_mc.md
Name: rob_mc

Overview:
- Parametrised, multi-port reorder buffer for the out-of-order core.
- Allocates one entry per cycle at dispatch and accepts NUM_WB independent CDB writebacks per cycle.
- Retires up to COMMIT_W completed entries per cycle, in program order, to the regfile/RAT.
- Detects a mispredicted branch at commit and issues a single-cycle flush with redirect PC. The flush resets the buffer.

Parameters:
- DEPTH, 32: entry count; power of two, >=4.
- IDX_W, $clog2(DEPTH): entry index width.
- NUM_WB, 4: writeback ports (alu, mul, mem, br).
- COMMIT_W, 2: max retirements per cycle; 1..4.
- DATA_W, 32: result width.
- ARCH_W, 5: architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_valid_i  in  1  dispatch requests an entry.
- alloc_ready_o  out  1  entry available this cycle.
- alloc_rd_i  in  ARCH_W  destination architectural register.
- alloc_we_i  in  1  instruction writes the regfile.
- alloc_pc_i  in  32  instruction PC.
- alloc_idx_o  out  IDX_W  index assigned to the current request.
- wb_valid_i  in  NUM_WB  per-port writeback strobe.
- wb_idx_i  in  NUM_WB*IDX_W  per-port target entry.
- wb_data_i  in  NUM_WB*DATA_W  per-port result.
- wb_mispred_i  in  NUM_WB  per-port branch mispredict flag.
- wb_pc_new_i  in  NUM_WB*32  per-port redirect target.
- commit_valid_o  out  COMMIT_W  slot k retiring candidate.
- commit_ready_i  in  1  consumer accepts all valid slots.
- commit_rd_o  out  COMMIT_W*ARCH_W  per-slot destination register.
- commit_we_o  out  COMMIT_W  per-slot regfile write enable.
- commit_data_o  out  COMMIT_W*DATA_W  per-slot result.
- commit_pc_o  out  COMMIT_W*32  per-slot PC.
- commit_idx_o  out  COMMIT_W*IDX_W  per-slot entry index.
- flush_o  out  1  mispredict flush pulse.
- flush_pc_o  out  32  redirect PC; valid only with flush_o.
- count_o  out  IDX_W+1  occupied entries.
- empty_o  out  1  count_o==0.
- full_o  out  1  count_o==DEPTH.

Behaviour:
- Pointers: head and tail are IDX_W+1 bits wide, with the MSB as a wrap bit.
  - count = tail-head, computed mod 2^(IDX_W+1).
  - full when count==DEPTH; empty when head==tail.
  - Pointers wrap naturally; no special case at DEPTH-1.
- Entry state is one of: FREE, WAIT, DONE.
  - Each entry stores rd, we, pc, data, mispred and pc_new.
- Reset: all entries FREE; head=tail=0.
  - Outputs after reset: alloc_ready_o=1, alloc_idx_o=0, commit_valid_o=0, flush_o=0, count_o=0, empty_o=1, full_o=0.
- Allocation:
  - alloc_ready_o = !full_o && !flush_o.
  - alloc_idx_o = tail[IDX_W-1:0], combinational, valid the same cycle as the request.
  - On alloc_valid_i && alloc_ready_o, the entry becomes WAIT with mispred=0, and tail increments at the edge.
  - A commit in the same cycle does not free a slot for allocation; a full buffer always refuses.
- Writeback:
  - For each port p with wb_valid_i[p]: if entry wb_idx_i[p] is WAIT, latch data/mispred/pc_new and set the entry to DONE at the edge.
  - Writebacks to FREE or DONE entries are ignored.
  - If two ports hit the same index in one cycle, the lowest port number wins.
- Commit (combinational from registered state):
  - Slot k is valid iff k < count, entry head+k is DONE, slot k-1 is valid (k>0), and no slot j<k has mispred=1.
  - Consequence: a mispredicted branch is always the last valid slot.
  - Earliest commit is the cycle after the writeback edge, so writeback-to-commit latency is 1 cycle.
  - When commit_ready_i=1, every valid slot retires at the edge: those entries become FREE and head advances by popcount(commit_valid_o).
  - When commit_ready_i=0, state is held and outputs stay stable.
- Flush:
  - flush_o = commit_ready_i && (some valid slot has mispred=1). It is combinational.
  - flush_pc_o = that slot's pc_new; otherwise 0.
  - At the edge with flush_o: all entries go FREE, head=tail=0, and that cycle's allocation and writebacks are discarded.
  - Instructions older than and including the branch retire normally in that cycle.
  - Next cycle the block is in the reset state.
- count_o, empty_o and full_o are derived from the registered pointers.
- Reset mid-operation (rst asserted with any traffic pending) overrides all activity; the block returns to the reset state next cycle.
- Assertions in RTL:
  - alloc_valid_i && !alloc_ready_o is legal (dispatch stalls).
  - Writeback to an index outside [head, tail) must be flagged.

Test Plan:
- Fill/drain (DEPTH=8, COMMIT_W=2):
  - Allocate 8 with no writeback -> full_o=1, alloc_ready_o=0, count_o=8.
  - Write back all 8 -> commits of 2,2,2,2 over 4 cycles; empty_o=1 after.
- Out-of-order writeback:
  - Allocate idx 0..3; write back 3,2,1 -> no commit.
  - Write back 0 -> next cycle commit_valid_o=2'b11 (0,1), then 2'b11 (2,3).
- Mispredict:
  - Allocate 0..4; complete all, with idx 1 mispred=1, pc_new=0x1234.
  - Commit cycle 1: slot0=idx0, slot1=idx1, flush_o=1, flush_pc_o=0x1234.
  - Next cycle count_o=0, alloc_idx_o=0.
- Wrap-around (DEPTH=8):
  - Allocate/commit 6, then allocate 6 more -> indices 6,7,0,1,2,3.
  - count_o=6; commits preserve that order.
- Same-cycle conflicts:
  - Ports 0 and 2 write idx 5 with 0xAA/0xBB -> committed data 0xAA.
  - Allocation during a flush cycle is not accepted; tail=0 next cycle.
- Backpressure/reset:
  - Hold commit_ready_i=0 for 3 cycles with 2 DONE entries -> outputs stable, head unchanged.
  - Assert rst with 5 entries pending -> next cycle count_o=0, commit_valid_o=0.
